// File: rtl/ahb_response_mux_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int NUM_SLV_DEFAULT = 5;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ahb_response_mux_if.sv
// Decoder/slave/master signals seen by the response mux.
interface ahb_response_mux_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = ahb_pkg::NUM_SLV_DEFAULT
);
    logic [NUM_SLV-1:0]            h_sel_x;
    logic [1:0]                    h_trans;
    logic [NUM_SLV*DATA_WIDTH-1:0] h_rdata_x;
    logic [NUM_SLV-1:0]            h_readyout_x;
    logic [NUM_SLV-1:0]            h_resp_x;
    logic [DATA_WIDTH-1:0]         h_rdata;
    logic                          h_ready;
    logic                          h_resp;

    // The mux itself
    modport slave (
        input  h_sel_x, h_trans, h_rdata_x, h_readyout_x, h_resp_x,
        output h_rdata, h_ready, h_resp
    );

    // Whoever drives the decoder/slave side and observes the response
    modport master (
        output h_sel_x, h_trans, h_rdata_x, h_readyout_x, h_resp_x,
        input  h_rdata, h_ready, h_resp
    );
endinterface

// File: rtl/ahb_response_mux_default_slave.sv
// Built-in default slave: two-cycle ERROR for active transfers to unmapped space.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic h_clk,
    input  logic h_resetn,
    input  logic h_ready,
    input  logic default_hit,
    output logic ds_active,
    output logic ds_ready,
    output logic ds_resp
);

    ds_state_t state_q, state_d;

    // State register, synchronous reset
    always_ff @(posedge h_clk) begin
        if (!h_resetn) state_q <= DS_IDLE;
        else           state_q <= state_d;
    end

    // Next state; ERR2 always has h_ready=1 so a new unmapped hit is accepted there
    always_comb begin
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (h_ready && default_hit) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = default_hit ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // Outputs depend on state only, keeping h_ready free of loops through this block
    assign ds_active = (state_q != DS_IDLE);
    assign ds_ready  = (state_q != DS_ERR1);
    assign ds_resp   = (state_q != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_response_mux.sv
// AHB-Lite data-phase response mux with registered select and default slave.
module ahb_response_mux
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = NUM_SLV_DEFAULT
) (
    input  logic               h_clk,
    input  logic               h_resetn,
    ahb_response_mux_if.slave  bus
);

    logic [NUM_SLV-1:0]    sel_dp_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  ready_d;
    logic                  resp_d;
    logic                  default_hit;
    logic                  ds_active, ds_ready, ds_resp;

    assign default_hit = (bus.h_sel_x == '0) &&
                         ((bus.h_trans == HTRANS_NONSEQ) || (bus.h_trans == HTRANS_SEQ));

    // Capture address-phase select only when the bus advances
    always_ff @(posedge h_clk) begin
        if (!h_resetn)    sel_dp_q <= '0;
        else if (ready_d) sel_dp_q <= bus.h_sel_x;
    end

    ahb_default_slave u_ds (
        .h_clk       (h_clk),
        .h_resetn    (h_resetn),
        .h_ready     (ready_d),
        .default_hit (default_hit),
        .ds_active   (ds_active),
        .ds_ready    (ds_ready),
        .ds_resp     (ds_resp)
    );

    // Data-phase mux: descending scan so the lowest set bit wins; default slave overrides
    always_comb begin
        rdata_d = '0;
        ready_d = 1'b1;
        resp_d  = HRESP_OKAY;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (sel_dp_q[i]) begin
                rdata_d = bus.h_rdata_x[i*DATA_WIDTH +: DATA_WIDTH];
                ready_d = bus.h_readyout_x[i];
                resp_d  = bus.h_resp_x[i];
            end
        end
        if (ds_active) begin
            rdata_d = '0;
            ready_d = ds_ready;
            resp_d  = ds_resp;
        end
    end

    assign bus.h_rdata = rdata_d;
    assign bus.h_ready = ready_d;
    assign bus.h_resp  = resp_d;

    // Decoder must never hand over more than one select
    a_sel_onehot: assert property (@(posedge h_clk) disable iff (!h_resetn) $onehot0(sel_dp_q))
        else $error("sel_dp multi-hot: %b", sel_dp_q);

endmodule
